// File: rtl/pic_priority_resolver_n_if.sv
// Bus between the PIC control/CPU-interface blocks and the priority resolver.
// PIC_SPECIAL_MASK_EN adds the special-mask-mode select smm.
interface pic_priority_resolver_n_if #(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned IDX_W   = 3
);
    logic [NUM_IRQ-1:0] ir_in;
    logic               level_mode;
    logic [NUM_IRQ-1:0] imr;
    logic               rotate_en;
    logic               inta;
    logic               eoi;
`ifdef PIC_SPECIAL_MASK_EN
    logic               smm;
`endif
    logic               int_out;
    logic [IDX_W-1:0]   vector;
    logic               vector_valid;
    logic [NUM_IRQ-1:0] irr;
    logic [NUM_IRQ-1:0] isr;

    modport master (
`ifdef PIC_SPECIAL_MASK_EN
        output smm,
`endif
        output ir_in, level_mode, imr, rotate_en, inta, eoi,
        input  int_out, vector, vector_valid, irr, isr
    );

    modport slave (
`ifdef PIC_SPECIAL_MASK_EN
        input  smm,
`endif
        input  ir_in, level_mode, imr, rotate_en, inta, eoi,
        output int_out, vector, vector_valid, irr, isr
    );
endinterface

// File: rtl/pic_priority_resolver_n.sv
// 8259A-style priority resolver: IRR/ISR, rotating priority, INTA/EOI handling.
// PIC_SPECIAL_MASK_EN enables special mask mode (blocker ignores masked ISR bits).
module pic_priority_resolver_n #(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned IDX_W   = 3
) (
    input logic                         clk,
    input logic                         reset,
    pic_priority_resolver_n_if.slave    bus
);

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] rank;  // 0 = highest priority
    } hit_t;

    // Scan from (low+1) mod N upward; first set bit wins.
    function automatic hit_t find_top(input logic [NUM_IRQ-1:0] req,
                                      input logic [IDX_W-1:0]   low);
        hit_t             h;
        logic [IDX_W-1:0] pos;
        h = '0;
        for (int unsigned k = 0; k < NUM_IRQ; k++) begin
            pos = IDX_W'((32'(low) + 32'd1 + k) % NUM_IRQ);
            if (!h.found && req[pos]) begin
                h.found = 1'b1;
                h.idx   = pos;
                h.rank  = IDX_W'(k);
            end
        end
        return h;
    endfunction

    logic [NUM_IRQ-1:0] irr_q, irr_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic [NUM_IRQ-1:0] ir_prev_q;
    logic [IDX_W-1:0]   lowest_ptr_q, lowest_ptr_d;
    logic               int_out_q, int_out_d;
    logic [IDX_W-1:0]   vector_q, vector_d;
    logic               vector_valid_q;

    hit_t               cand_hit;
    hit_t               blk_hit;
    hit_t               eoi_hit;
    logic               pending;
    logic               ack;
    logic [NUM_IRQ-1:0] ack_mask;
    logic [NUM_IRQ-1:0] edge_set;

    assign cand_hit = find_top(irr_q & ~bus.imr, lowest_ptr_q);
    assign eoi_hit  = find_top(isr_q, lowest_ptr_q);

`ifdef PIC_SPECIAL_MASK_EN
    assign blk_hit  = bus.smm ? find_top(isr_q & ~bus.imr, lowest_ptr_q) : eoi_hit;
`else
    assign blk_hit  = eoi_hit;
`endif

    // An equal-rank candidate (same line already in service) is not pending.
    assign pending  = cand_hit.found && (!blk_hit.found || (cand_hit.rank < blk_hit.rank));
    assign ack      = bus.inta && int_out_q && cand_hit.found;
    assign edge_set = bus.ir_in & ~ir_prev_q;

    always_comb begin
        ack_mask = '0;
        if (ack) begin
            ack_mask[cand_hit.idx] = 1'b1;
        end
    end

    always_comb begin
        irr_d        = irr_q;
        isr_d        = isr_q;
        lowest_ptr_d = lowest_ptr_q;
        vector_d     = vector_q;

        if (bus.level_mode) begin
            irr_d = bus.ir_in & ~ack_mask;
        end else begin
            irr_d = (irr_q & ~ack_mask) | edge_set;
        end

        // EOI clear and INTA set share the edge; the set wins on the same bit.
        if (bus.eoi && eoi_hit.found) begin
            isr_d[eoi_hit.idx] = 1'b0;
            if (bus.rotate_en) begin
                lowest_ptr_d = eoi_hit.idx;
            end
        end
        isr_d = isr_d | ack_mask;

        if (ack) begin
            vector_d = cand_hit.idx;
        end

        int_out_d = ack ? 1'b0 : pending;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irr_q          <= '0;
            isr_q          <= '0;
            ir_prev_q      <= '0;
            lowest_ptr_q   <= IDX_W'(NUM_IRQ - 1);
            int_out_q      <= 1'b0;
            vector_q       <= '0;
            vector_valid_q <= 1'b0;
        end else begin
            irr_q          <= irr_d;
            isr_q          <= isr_d;
            ir_prev_q      <= bus.ir_in;
            lowest_ptr_q   <= lowest_ptr_d;
            int_out_q      <= int_out_d;
            vector_q       <= vector_d;
            vector_valid_q <= ack;
        end
    end

    assign bus.int_out      = int_out_q;
    assign bus.vector       = vector_q;
    assign bus.vector_valid = vector_valid_q;
    assign bus.irr          = irr_q;
    assign bus.isr          = isr_q;

endmodule

// File: tb/tb_pic_priority_resolver_n.sv
// Directed plus random bench for pic_priority_resolver_n against a rank-based model.
module tb_pic_priority_resolver_n;

    localparam int NI = 8;
    localparam int WI = 3;

    logic clk = 1'b0;
    logic reset;

    pic_priority_resolver_n_if #(.NUM_IRQ(NI), .IDX_W(WI)) bus ();

    pic_priority_resolver_n #(.NUM_IRQ(NI), .IDX_W(WI)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [NI-1:0] m_irr, m_isr, m_prev;
    int            m_low, m_vec;
    logic          m_int, m_vv;

    // Position in the priority order: 0 is highest.
    function automatic int rank_of(input int i, input int low);
        return (i - low - 1 + 2 * NI) % NI;
    endfunction

    function automatic int top_of(input logic [NI-1:0] v, input int low);
        int best;
        best = -1;
        for (int i = 0; i < NI; i++) begin
            if (v[i] && (best < 0 || rank_of(i, low) < rank_of(best, low))) best = i;
        end
        return best;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic [NI-1:0] n_irr, n_isr, n_prev, cmask;
        int            n_low, n_vec, c, b;
        logic          n_int, n_vv, acc, pend;
        if (reset) begin
            n_irr = '0; n_isr = '0; n_prev = '0; n_low = NI - 1;
            n_int = 1'b0; n_vec = 0; n_vv = 1'b0;
        end else begin
            c     = top_of(m_irr & ~bus.imr, m_low);
            b     = top_of(m_isr, m_low);
`ifdef PIC_SPECIAL_MASK_EN
            pend  = (c >= 0) && (top_of(bus.smm ? (m_isr & ~bus.imr) : m_isr, m_low) < 0 ||
                     rank_of(c, m_low) <
                     rank_of(top_of(bus.smm ? (m_isr & ~bus.imr) : m_isr, m_low), m_low));
`else
            pend  = (c >= 0) && (b < 0 || rank_of(c, m_low) < rank_of(b, m_low));
`endif
            acc   = bus.inta && m_int && (c >= 0);
            cmask = '0;
            if (acc) cmask[c[WI-1:0]] = 1'b1;
            if (bus.level_mode) n_irr = bus.ir_in & ~cmask;
            else                n_irr = (m_irr & ~cmask) | (bus.ir_in & ~m_prev);
            n_isr = m_isr;
            n_low = m_low;
            if (bus.eoi && b >= 0) begin
                n_isr[b[WI-1:0]] = 1'b0;
                if (bus.rotate_en) n_low = b;
            end
            n_isr  = n_isr | cmask;
            n_int  = acc ? 1'b0 : pend;
            n_vec  = acc ? c : m_vec;
            n_vv   = acc;
            n_prev = bus.ir_in;
        end
        @(posedge clk);
        m_irr = n_irr; m_isr = n_isr; m_prev = n_prev; m_low = n_low;
        m_int = n_int; m_vec = n_vec; m_vv = n_vv;
        #1;
        check("irr",          32'(bus.irr),          32'(m_irr));
        check("isr",          32'(bus.isr),          32'(m_isr));
        check("int_out",      32'(bus.int_out),      32'(m_int));
        check("vector",       32'(bus.vector),       32'(m_vec));
        check("vector_valid", 32'(bus.vector_valid), 32'(m_vv));
    endtask

    task automatic pulse_ir(input logic [NI-1:0] v);
        bus.ir_in = v; tick();
        bus.ir_in = '0; tick();
    endtask

    task automatic do_inta();
        bus.inta = 1'b1; tick(); bus.inta = 1'b0;
    endtask

    task automatic do_eoi();
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.ir_in = '0; bus.level_mode = 1'b0; bus.imr = '0; bus.rotate_en = 1'b0;
        bus.inta = 1'b0; bus.eoi = 1'b0;
`ifdef PIC_SPECIAL_MASK_EN
        bus.smm = 1'b0;
`endif
        m_irr = '0; m_isr = '0; m_prev = '0; m_low = NI - 1;
        m_int = 1'b0; m_vec = 0; m_vv = 1'b0;
        #2;
        tick();
        reset = 1'b0;
        check("rst_irr", 32'(bus.irr), 32'h0);
        check("rst_int", 32'(bus.int_out), 32'h0);

        // Single edge request on IR2
        bus.ir_in = 8'h04; tick();
        check("t1_irr", 32'(bus.irr), 32'h04);
        check("t1_int_early", 32'(bus.int_out), 32'h0);
        bus.ir_in = 8'h00; tick();
        check("t1_int", 32'(bus.int_out), 32'h1);
        do_inta();
        check("t1_vec", 32'(bus.vector), 32'd2);
        check("t1_vv", 32'(bus.vector_valid), 32'h1);
        check("t1_isr", 32'(bus.isr), 32'h04);
        tick();
        check("t1_vv_drop", 32'(bus.vector_valid), 32'h0);
        do_eoi();

        // Masked IR3 alongside IR5
        bus.imr = 8'h08;
        pulse_ir(8'h28);
        do_inta();
        check("t2_vec5", 32'(bus.vector), 32'd5);
        do_eoi();
        check("t2_isr", 32'(bus.isr), 32'h0);
        tick(); tick();
        check("t2_masked", 32'(bus.int_out), 32'h0);
        bus.imr = 8'h00; tick();
        do_inta();
        check("t2_vec3", 32'(bus.vector), 32'd3);
        do_eoi();

        // Fully nested blocking
        pulse_ir(8'h10);
        do_inta();
        pulse_ir(8'h40);
        tick();
        check("t3_blocked", 32'(bus.int_out), 32'h0);
        pulse_ir(8'h02);
        check("t3_nest_int", 32'(bus.int_out), 32'h1);
        do_inta();
        check("t3_vec1", 32'(bus.vector), 32'd1);
        check("t3_isr12", 32'(bus.isr), 32'h12);
        do_eoi();
        check("t3_eoi1", 32'(bus.isr), 32'h10);
        do_eoi();
        check("t3_eoi2", 32'(bus.isr), 32'h00);
        tick();
        do_inta();
        check("t3_vec6", 32'(bus.vector), 32'd6);
        do_eoi();

        // Automatic rotation
        bus.rotate_en = 1'b1;
        pulse_ir(8'h01);
        do_inta();
        do_eoi();
        pulse_ir(8'h81);
        do_inta();
        check("t4_vec7", 32'(bus.vector), 32'd7);
        do_eoi();
        tick();
        do_inta();
        check("t4_vec0", 32'(bus.vector), 32'd0);
        bus.rotate_en = 1'b0;
        do_eoi();

        // Level mode
        bus.level_mode = 1'b1;
        bus.ir_in = 8'h08; tick(); tick();
        do_inta();
        check("t5_vec3", 32'(bus.vector), 32'd3);
        check("t5_irr_clr", 32'(bus.irr), 32'h00);
        tick();
        check("t5_irr_re", 32'(bus.irr), 32'h08);
        do_eoi();
        tick();
        do_inta();
        check("t5_vec3b", 32'(bus.vector), 32'd3);
        do_eoi();
        bus.ir_in = 8'h00; tick(); tick();
        check("t5_drop", 32'(bus.int_out), 32'h0);
        bus.level_mode = 1'b0;

        // Simultaneous INTA and EOI, then reset mid-service
        pulse_ir(8'h02);
        do_inta();
        pulse_ir(8'h01);
        check("t6_int", 32'(bus.int_out), 32'h1);
        bus.inta = 1'b1; bus.eoi = 1'b1; tick();
        bus.inta = 1'b0; bus.eoi = 1'b0;
        check("t6_isr", 32'(bus.isr), 32'h01);
        check("t6_vec", 32'(bus.vector), 32'd0);
        bus.ir_in = 8'h04; tick();
        bus.ir_in = 8'h00;
        reset = 1'b1; tick(); reset = 1'b0;
        check("t6_rst_isr", 32'(bus.isr), 32'h0);
        check("t6_rst_irr", 32'(bus.irr), 32'h0);
        check("t6_rst_vv", 32'(bus.vector_valid), 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            bus.ir_in = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 15) == 0) bus.imr = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 63) == 0) bus.level_mode = ~bus.level_mode;
            if ($urandom_range(0, 31) == 0) bus.rotate_en = ~bus.rotate_en;
            bus.inta = ($urandom_range(0, 2) == 0);
            bus.eoi  = ($urandom_range(0, 5) == 0);
            reset    = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0; bus.inta = 1'b0; bus.eoi = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
